// File: rtl/ioctl_pkg.sv
// Shared types and helpers for the ioctl download path (ROM packer, save-RAM path).
// The struct and localparams describe the default 16-bit beat / 64-bit word build.
package ioctl_pkg;

    localparam int DFLT_IO_W   = 16;
    localparam int DFLT_MEM_W  = 64;
    localparam int DFLT_ADDR_W = 25;

    localparam int LANES = DFLT_MEM_W / DFLT_IO_W;
    localparam int BE_W  = DFLT_MEM_W / 8;

    typedef struct packed {
        logic [DFLT_ADDR_W-1:0] addr;
        logic [DFLT_MEM_W-1:0]  data;
        logic [BE_W-1:0]        be;
    } fifo_entry_t;

    // Which io_w-wide lane of a mem_w-wide word a byte address falls into.
    function automatic int lane_idx(input logic [31:0] addr, input int io_w, input int mem_w);
        return int'((addr % 32'(mem_w / 8)) / 32'(io_w / 8));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count; push and pop may coincide.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/ioctl_rom_packer.sv
// Packs narrow ioctl download beats into wide byte-enabled memory words and
// hands them to a toggle-handshake writer through a small FIFO.
module ioctl_rom_packer
    import ioctl_pkg::*;
#(
    parameter int IO_W   = 16,
    parameter int MEM_W  = 64,
    parameter int ADDR_W = 25,
    parameter int DEPTH  = 4,
    parameter bit SWAP   = 1'b1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [IO_W-1:0]      ioctl_dout,
    output logic                 ioctl_wait,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [MEM_W-1:0]     mem_din,
    output logic [MEM_W/8-1:0]   mem_be,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [ADDR_W-1:0]    rom_size,
    output logic                 busy
);

    localparam int IO_BYTES  = IO_W / 8;
    localparam int MEM_BYTES = MEM_W / 8;
    localparam int N_LANES   = MEM_W / IO_W;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [MEM_W-1:0]     data;
        logic [MEM_BYTES-1:0] be;
    } word_t;

    logic                 dl_q;
    logic [ADDR_W-1:0]    asm_addr_q, asm_addr_d;
    logic [MEM_W-1:0]     asm_data_q, asm_data_d;
    logic [MEM_BYTES-1:0] asm_be_q, asm_be_d;
    logic [ADDR_W-1:0]    rom_size_q, rom_size_d;
    logic                 wait_q, wait_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [MEM_W-1:0]     mem_din_q, mem_din_d;
    logic [MEM_BYTES-1:0] mem_be_q, mem_be_d;
    logic                 mem_req_q, mem_req_d;

    logic                 rise, fall, jump;
    int                   lane;
    logic [ADDR_W-1:0]    beat_waddr, end_addr;
    logic [IO_W-1:0]      beat_data;
    logic [ADDR_W-1:0]    base_addr, base_size;
    logic [MEM_W-1:0]     base_data, lane_data, lane_mask, new_data;
    logic [MEM_BYTES-1:0] base_be, lane_be, new_be;
    logic                 push;
    word_t                push_word, head;
    logic                 fifo_pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0]     fifo_count, occ_next;

    always_comb begin
        rise       = ioctl_download && !dl_q;
        fall       = !ioctl_download && dl_q;
        lane       = lane_idx(32'(ioctl_addr), IO_W, MEM_W);
        beat_waddr = ioctl_addr & ~ADDR_W'(MEM_BYTES - 1);
        end_addr   = ioctl_addr + ADDR_W'(IO_BYTES);

        beat_data = ioctl_dout;
        if (SWAP) begin
            for (int b = 0; b < IO_BYTES; b++) begin
                beat_data[b*8 +: 8] = ioctl_dout[(IO_BYTES-1-b)*8 +: 8];
            end
        end

        lane_data = MEM_W'(beat_data) << (lane * IO_W);
        lane_mask = MEM_W'({IO_W{1'b1}}) << (lane * IO_W);
        lane_be   = MEM_BYTES'({IO_BYTES{1'b1}}) << (lane * IO_BYTES);

        // A rising download edge starts from a clean assembly word and size.
        base_addr = rise ? '0 : asm_addr_q;
        base_data = rise ? '0 : asm_data_q;
        base_be   = rise ? '0 : asm_be_q;
        base_size = rise ? '0 : rom_size_q;

        jump = ioctl_wr && (base_be != '0) && (beat_waddr != base_addr);
        if (jump || base_be == '0) begin
            new_data = lane_data;
            new_be   = lane_be;
        end else begin
            new_data = (base_data & ~lane_mask) | lane_data;
            new_be   = base_be | lane_be;
        end

        push       = 1'b0;
        push_word  = '{addr: base_addr, data: base_data, be: base_be};
        asm_addr_d = base_addr;
        asm_data_d = base_data;
        asm_be_d   = base_be;
        rom_size_d = base_size;

        if (ioctl_wr) begin
            if (end_addr > base_size) begin
                rom_size_d = end_addr;
            end
            asm_addr_d = beat_waddr;
            if (jump) begin
                // Old word goes out now; a top-lane beat here waits for the next push event.
                push       = 1'b1;
                asm_data_d = new_data;
                asm_be_d   = new_be;
            end else if (lane == N_LANES - 1) begin
                push       = 1'b1;
                push_word  = '{addr: beat_waddr, data: new_data, be: new_be};
                asm_data_d = '0;
                asm_be_d   = '0;
            end else begin
                asm_data_d = new_data;
                asm_be_d   = new_be;
            end
        end else if (fall && base_be != '0) begin
            push       = 1'b1;
            asm_data_d = '0;
            asm_be_d   = '0;
        end

        fifo_pop   = !fifo_empty && (mem_req_q == mem_ack);
        mem_addr_d = fifo_pop ? head.addr : mem_addr_q;
        mem_din_d  = fifo_pop ? head.data : mem_din_q;
        mem_be_d   = fifo_pop ? head.be   : mem_be_q;
        mem_req_d  = mem_req_q ^ fifo_pop;

        // Stall on next-cycle occupancy so a beat already in flight still fits.
        occ_next = fifo_count + CNT_W'(push) - CNT_W'(fifo_pop);
        wait_d   = (occ_next >= CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            asm_addr_q <= '0;
            asm_data_q <= '0;
            asm_be_q   <= '0;
            rom_size_q <= '0;
            wait_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            asm_addr_q <= asm_addr_d;
            asm_data_q <= asm_data_d;
            asm_be_q   <= asm_be_d;
            rom_size_q <= rom_size_d;
            wait_q     <= wait_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_be_q   <= mem_be_d;
            mem_req_q  <= mem_req_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(word_t))
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .push  (push),
        .wdata (push_word),
        .pop   (fifo_pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    a_no_push_when_full : assert property (
        @(posedge clk_sys) disable iff (!reset_n) !(push && fifo_full && !fifo_pop)
    );

    assign ioctl_wait = wait_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_be     = mem_be_q;
    assign mem_req    = mem_req_q;
    assign rom_size   = rom_size_q;
    assign busy       = (asm_be_q != '0) || !fifo_empty || (mem_req_q != mem_ack);

endmodule

// File: tb/tb_ioctl_rom_packer.sv
// Directed bench for ioctl_rom_packer: a 16->64 swapping build and an 8->32 build.
module tb_ioctl_rom_packer;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        dl, wr, wait16, mreq, mack, busy;
    logic [24:0] addr, maddr, rsize;
    logic [15:0] dout;
    logic [63:0] mdin;
    logic [7:0]  mbe;

    logic        dl8, wr8, wait8, mreq8, mack8, busy8;
    logic [24:0] addr8, maddr8, rsize8;
    logic [7:0]  dout8;
    logic [31:0] mdin8;
    logic [3:0]  mbe8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] bp_words [4];

    always #5 clk = ~clk;

    ioctl_rom_packer #(
        .IO_W(16), .MEM_W(64), .ADDR_W(25), .DEPTH(4), .SWAP(1'b1)
    ) u_dut (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait16),
        .mem_addr(maddr), .mem_din(mdin), .mem_be(mbe), .mem_req(mreq),
        .mem_ack(mack), .rom_size(rsize), .busy(busy)
    );

    ioctl_rom_packer #(
        .IO_W(8), .MEM_W(32), .ADDR_W(25), .DEPTH(4), .SWAP(1'b0)
    ) u_dut8 (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl8), .ioctl_wr(wr8),
        .ioctl_addr(addr8), .ioctl_dout(dout8), .ioctl_wait(wait8),
        .mem_addr(maddr8), .mem_din(mdin8), .mem_be(mbe8), .mem_req(mreq8),
        .mem_ack(mack8), .rom_size(rsize8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [24:0] a, input logic [15:0] d);
        wr = 1'b1; addr = a; dout = d;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic beat8(input logic [24:0] a, input logic [7:0] d);
        wr8 = 1'b1; addr8 = a; dout8 = d;
        tick(1);
        wr8 = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [24:0] a,
                               input logic [63:0] d, input logic [7:0] b);
        int n = 0;
        while (mreq === mack && n < 20) begin
            tick(1);
            n++;
        end
        check({tag, "_req"}, 64'(mreq !== mack), 64'd1);
        check({tag, "_addr"}, 64'(maddr), 64'(a));
        check({tag, "_din"}, mdin, d);
        check({tag, "_be"}, 64'(mbe), 64'(b));
        mack = mreq;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bp_words[0] = 64'hB3A0_B2A0_B1A0_B0A0;
        bp_words[1] = 64'hB3A1_B2A1_B1A1_B0A1;
        bp_words[2] = 64'hB3A2_B2A2_B1A2_B0A2;
        bp_words[3] = 64'hB3A3_B2A3_B1A3_B0A3;

        reset_n = 1'b0;
        dl = 0; wr = 0; addr = '0; dout = '0; mack = 0;
        dl8 = 0; wr8 = 0; addr8 = '0; dout8 = '0; mack8 = 0;
        tick(3);
        check("rst_wait", 64'(wait16), 64'd0);
        check("rst_addr", 64'(maddr), 64'd0);
        check("rst_din", mdin, 64'd0);
        check("rst_be", 64'(mbe), 64'd0);
        check("rst_req", 64'(mreq), 64'd0);
        check("rst_size", 64'(rsize), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Full word, byte swap on
        dl = 1; tick(1);
        beat(25'h0, 16'h1122);
        beat(25'h2, 16'h3344);
        beat(25'h4, 16'h5566);
        beat(25'h6, 16'h7788);
        check("full_req_t1", 64'(mreq), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        tick(1);
        check("full_req_t2", 64'(mreq), 64'd1);
        expect_word("full", 25'h0, 64'h8877_6655_4433_2211, 8'hFF);
        check("full_size", 64'(rsize), 64'h8);
        dl = 0; tick(3);
        check("full_noflush_req", 64'(mreq), 64'd1);
        check("full_idle", 64'(busy), 64'd0);

        // Partial word flushed at end of download
        dl = 1; tick(1);
        check("flush_size_clr", 64'(rsize), 64'd0);
        beat(25'h0A, 16'hABCD);
        check("flush_size", 64'(rsize), 64'h0C);
        dl = 0; tick(1);
        expect_word("flush", 25'h08, 64'h0000_0000_CDAB_0000, 8'h0C);
        check("flush_size_kept", 64'(rsize), 64'h0C);

        // Address jump pushes the old word first
        dl = 1; tick(1);
        beat(25'h00, 16'h1234);
        beat(25'h40, 16'h5678);
        expect_word("jump0", 25'h00, 64'h3412, 8'h03);
        check("jump_busy", 64'(busy), 64'd1);
        dl = 0; tick(1);
        expect_word("jump1", 25'h40, 64'h7856, 8'h03);
        check("jump_size", 64'(rsize), 64'h42);

        // Backpressure: ack held; first word goes straight to the output register
        dl = 1; tick(1);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("bp_wait_lo%0d", w), 64'(wait16), 64'd0);
            for (int l = 0; l < 4; l++) begin
                beat(25'h100 + 25'(w * 8 + l * 2), {4'hA, 4'(w), 4'hB, 4'(l)});
            end
        end
        check("bp_wait_hi", 64'(wait16), 64'd1);
        tick(3);
        check("bp_wait_hold", 64'(wait16), 64'd1);
        expect_word("bp0", 25'h100, bp_words[0], 8'hFF);
        check("bp_wait_rel", 64'(wait16), 64'd0);
        for (int w = 1; w < 4; w++) begin
            expect_word($sformatf("bp%0d", w), 25'h100 + 25'(w * 8), bp_words[w], 8'hFF);
        end
        check("bp_size", 64'(rsize), 64'h120);
        dl = 0; tick(3);
        check("bp_idle", 64'(busy), 64'd0);

        // Reset with two words queued
        dl = 1; tick(1);
        for (int i = 0; i < 8; i++) begin
            beat(25'h200 + 25'(i * 2), 16'(16'h0101 * i));
        end
        tick(1);
        check("rstm_req_pre", 64'(mreq), 64'd1);
        check("rstm_busy_pre", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0; mack = 1'b0; dl = 1'b0;
        #1;
        check("rstm_req", 64'(mreq), 64'd0);
        check("rstm_addr", 64'(maddr), 64'd0);
        check("rstm_din", mdin, 64'd0);
        check("rstm_be", 64'(mbe), 64'd0);
        check("rstm_size", 64'(rsize), 64'd0);
        check("rstm_wait", 64'(wait16), 64'd0);
        check("rstm_busy", 64'(busy), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        check("rstm_no_req", 64'(mreq), 64'd0);
        check("rstm_idle", 64'(busy), 64'd0);

        // Narrow 8-bit beats into 32-bit words
        dl8 = 1; tick(1);
        beat8(25'h0, 8'h01);
        beat8(25'h1, 8'h02);
        beat8(25'h2, 8'h03);
        beat8(25'h3, 8'h04);
        begin
            int n = 0;
            while (mreq8 === mack8 && n < 20) begin
                tick(1);
                n++;
            end
        end
        check("n8_req", 64'(mreq8), 64'd1);
        check("n8_addr", 64'(maddr8), 64'd0);
        check("n8_din", 64'(mdin8), 64'h0403_0201);
        check("n8_be", 64'(mbe8), 64'hF);
        check("n8_size", 64'(rsize8), 64'h4);
        mack8 = mreq8;
        dl8 = 0; tick(3);
        check("n8_idle", 64'(busy8), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
